// File: rtl/zuse_fp_adder.sv
// Serial Z3-format floating-point adder: 7-bit two's-complement exponent, 15-bit mantissa.
// Captures operands on add, aligns one bit per cycle, adds, normalizes, publishes on return to idle.
module zuse_fp_adder (
  input  logic        clk_10MHZ,
  input  logic        rst_n,
  input  logic        add,
  input  logic [6:0]  reg1_e,
  input  logic [14:0] reg1_m,
  input  logic [6:0]  reg2_e,
  input  logic [14:0] reg2_m,
  output logic [6:0]  res_e,
  output logic [14:0] res_m,
  output logic        ovf,
  output logic        idle
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMP, S_ALIGN, S_ADD, S_NORM, S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [6:0]  ea, eb, ea_nx, eb_nx;
  logic [14:0] ma, mb, ma_nx, mb_nx;
  logic [7:0]  d, d_nx;
  logic [15:0] sum, sum_nx;
  logic        ovf_pend, ovf_pend_nx;
  logic [6:0]  res_e_nx;
  logic [14:0] res_m_nx;
  logic        ovf_nx;

  logic        swap;
  logic [6:0]  hi_e, lo_e;
  logic [14:0] hi_m, lo_m;
  logic [7:0]  diff;

  assign swap = $signed(eb) > $signed(ea);
  assign hi_e = swap ? eb : ea;
  assign lo_e = swap ? ea : eb;
  assign hi_m = swap ? mb : ma;
  assign lo_m = swap ? ma : mb;
  assign diff = {hi_e[6], hi_e} - {lo_e[6], lo_e};

  assign idle = (state == S_IDLE);

  always_ff @(posedge clk_10MHZ) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ea       <= '0;
      eb       <= '0;
      ma       <= '0;
      mb       <= '0;
      d        <= '0;
      sum      <= '0;
      ovf_pend <= 1'b0;
      res_e    <= '0;
      res_m    <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nx;
      ea       <= ea_nx;
      eb       <= eb_nx;
      ma       <= ma_nx;
      mb       <= mb_nx;
      d        <= d_nx;
      sum      <= sum_nx;
      ovf_pend <= ovf_pend_nx;
      res_e    <= res_e_nx;
      res_m    <= res_m_nx;
      ovf      <= ovf_nx;
    end
  end

  // ea/ma double as the result staging register; S_DONE publishes them so that
  // every path (early exit or full) updates the outputs on the idle-return edge.
  always_comb begin
    state_nx    = state;
    ea_nx       = ea;
    eb_nx       = eb;
    ma_nx       = ma;
    mb_nx       = mb;
    d_nx        = d;
    sum_nx      = sum;
    ovf_pend_nx = ovf_pend;
    res_e_nx    = res_e;
    res_m_nx    = res_m;
    ovf_nx      = ovf;
    case (state)
      S_IDLE: begin
        if (add) begin
          ea_nx       = reg1_e;
          ma_nx       = reg1_m;
          eb_nx       = reg2_e;
          mb_nx       = reg2_m;
          ovf_nx      = 1'b0;
          ovf_pend_nx = 1'b0;
          state_nx    = S_CMP;
        end
      end
      S_CMP: begin
        if (ma == '0) begin
          ea_nx    = eb;
          ma_nx    = mb;
          state_nx = S_DONE;
        end else if (mb == '0) begin
          state_nx = S_DONE;
        end else begin
          ea_nx = hi_e;
          ma_nx = hi_m;
          eb_nx = lo_e;
          mb_nx = lo_m;
          d_nx  = diff;
          if (diff > 8'd15)
            state_nx = S_DONE;
          else if (diff == 8'd0)
            state_nx = S_ADD;
          else
            state_nx = S_ALIGN;
        end
      end
      S_ALIGN: begin
        mb_nx = mb >> 1;
        d_nx  = d - 8'd1;
        if (d == 8'd1)
          state_nx = S_ADD;
      end
      S_ADD: begin
        sum_nx   = {1'b0, ma} + {1'b0, mb};
        state_nx = S_NORM;
      end
      S_NORM: begin
        if (!sum[15]) begin
          ma_nx = sum[14:0];
        end else if (ea != 7'd63) begin
          ea_nx = ea + 7'd1;
          ma_nx = sum[15:1];
        end else begin
          ea_nx       = 7'd63;
          ma_nx       = '1;
          ovf_pend_nx = 1'b1;
        end
        state_nx = S_DONE;
      end
      S_DONE: begin
        res_e_nx = ea;
        res_m_nx = ma;
        ovf_nx   = ovf_pend;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_zuse_fp_adder.sv
// Self-checking bench for zuse_fp_adder: directed cases plus randomized operands
// checked against an arithmetic reference model.
module tb_zuse_fp_adder;

  logic        clk_10MHZ = 1'b0;
  logic        rst_n     = 1'b0;
  logic        add       = 1'b0;
  logic [6:0]  reg1_e    = '0;
  logic [14:0] reg1_m    = '0;
  logic [6:0]  reg2_e    = '0;
  logic [14:0] reg2_m    = '0;
  logic [6:0]  res_e;
  logic [14:0] res_m;
  logic        ovf;
  logic        idle;

  int n_assert = 0;
  int n_fail   = 0;

  zuse_fp_adder dut (
    .clk_10MHZ (clk_10MHZ),
    .rst_n     (rst_n),
    .add       (add),
    .reg1_e    (reg1_e),
    .reg1_m    (reg1_m),
    .reg2_e    (reg2_e),
    .reg2_m    (reg2_m),
    .res_e     (res_e),
    .res_m     (res_m),
    .ovf       (ovf),
    .idle      (idle)
  );

  always #50 clk_10MHZ = ~clk_10MHZ;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value-level arithmetic on integer mantissas and exponents.
  task automatic ref_add(input logic [6:0] e1, input logic [14:0] m1,
                         input logic [6:0] e2, input logic [14:0] m2,
                         output logic [6:0] re, output logic [14:0] rm,
                         output logic rovf, output int lat);
    int x, y, a, b, t, dd, s;
    x = $signed(e1); y = $signed(e2); a = m1; b = m2;
    rovf = 1'b0;
    if (a == 0) begin
      re = e2; rm = m2; lat = 2;
    end else if (b == 0) begin
      re = e1; rm = m1; lat = 2;
    end else begin
      if (y > x) begin
        t = x; x = y; y = t;
        t = a; a = b; b = t;
      end
      dd = x - y;
      if (dd > 15) begin
        re = x[6:0]; rm = a[14:0]; lat = 2;
      end else begin
        lat = dd + 4;
        s = a + (b / (1 << dd));
        if (s < 32768) begin
          re = x[6:0]; rm = s[14:0];
        end else if (x == 63) begin
          re = 7'd63; rm = 15'h7FFF; rovf = 1'b1;
        end else begin
          t = x + 1; s = s / 2;
          re = t[6:0]; rm = s[14:0];
        end
      end
    end
  endtask

  task automatic start_op(input logic [6:0] e1, input logic [14:0] m1,
                          input logic [6:0] e2, input logic [14:0] m2);
    @(negedge clk_10MHZ);
    reg1_e = e1; reg1_m = m1; reg2_e = e2; reg2_m = m2;
    add = 1'b1;
    @(posedge clk_10MHZ);
    #1;
    add = 1'b0;
    reg1_e = 7'($urandom); reg1_m = 15'($urandom);
    reg2_e = 7'($urandom); reg2_m = 15'($urandom);
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!idle && n < 60) begin
      @(posedge clk_10MHZ);
      #1;
      n++;
    end
  endtask

  task automatic run_fixed(input string tag,
                           input logic [6:0] e1, input logic [14:0] m1,
                           input logic [6:0] e2, input logic [14:0] m2,
                           input logic [6:0] xe, input logic [14:0] xm,
                           input logic xovf, input int xlat);
    int n;
    start_op(e1, m1, e2, m2);
    check({tag, "_busy"}, idle, 1'b0);
    check({tag, "_ovf_clr"}, ovf, 1'b0);
    wait_done(0, n);
    check({tag, "_lat"}, n, xlat);
    check({tag, "_e"}, res_e, xe);
    check({tag, "_m"}, res_m, xm);
    check({tag, "_ovf"}, ovf, xovf);
  endtask

  initial begin
    logic [6:0]  e1, e2, xe;
    logic [14:0] m1, m2, xm;
    logic        xovf;
    int          xlat, n;

    repeat (2) @(posedge clk_10MHZ);
    #1;
    check("rst_idle", idle, 1'b1);
    check("rst_e", res_e, 7'd0);
    check("rst_m", res_m, 15'd0);
    check("rst_ovf", ovf, 1'b0);
    @(negedge clk_10MHZ);
    rst_n = 1'b1;

    run_fixed("equal",    7'd0,   15'h4000, 7'd0,   15'h4000, 7'd1,  15'h4000, 1'b0, 4);
    run_fixed("d2",       7'd0,   15'h4000, 7'h7E,  15'h4000, 7'd0,  15'h5000, 1'b0, 6);
    run_fixed("d2_swap",  7'h7E,  15'h4000, 7'd0,   15'h4000, 7'd0,  15'h5000, 1'b0, 6);
    run_fixed("zero_a",   7'd9,   15'h0000, 7'd5,   15'h6000, 7'd5,  15'h6000, 1'b0, 2);
    run_fixed("zero_b",   7'd3,   15'h5555, 7'd40,  15'h0000, 7'd3,  15'h5555, 1'b0, 2);
    run_fixed("far",      7'd20,  15'h4000, 7'd0,   15'h7FFF, 7'd20, 15'h4000, 1'b0, 2);
    run_fixed("d15",      7'd15,  15'h4000, 7'd0,   15'h7FFF, 7'd15, 15'h4000, 1'b0, 19);
    run_fixed("sat",      7'd63,  15'h7FFF, 7'd63,  15'h7FFF, 7'd63, 15'h7FFF, 1'b1, 4);
    run_fixed("after_sat",7'd1,   15'h6000, 7'd1,   15'h6000, 7'd2,  15'h6000, 1'b0, 4);

    // Second strobe during ALIGN must be ignored and not queued.
    start_op(7'd10, 15'h4000, 7'd0, 15'h4000);
    n = 0;
    repeat (3) begin
      @(posedge clk_10MHZ);
      #1;
      n++;
    end
    reg1_e = 7'd0; reg1_m = 15'h7000; reg2_e = 7'd0; reg2_m = 15'h7000;
    add = 1'b1;
    @(posedge clk_10MHZ);
    #1;
    n++;
    add = 1'b0;
    wait_done(n, n);
    check("mid_lat", n, 14);
    check("mid_e", res_e, 7'd10);
    check("mid_m", res_m, 15'h4010);
    repeat (4) @(posedge clk_10MHZ);
    #1;
    check("mid_hold_idle", idle, 1'b1);
    check("mid_hold_e", res_e, 7'd10);
    check("mid_hold_m", res_m, 15'h4010);

    // Reset during ALIGN aborts immediately.
    start_op(7'd10, 15'h4000, 7'd0, 15'h4000);
    repeat (5) @(posedge clk_10MHZ);
    @(negedge clk_10MHZ);
    rst_n = 1'b0;
    @(posedge clk_10MHZ);
    #1;
    check("abort_idle", idle, 1'b1);
    check("abort_e", res_e, 7'd0);
    check("abort_m", res_m, 15'd0);
    check("abort_ovf", ovf, 1'b0);
    @(negedge clk_10MHZ);
    rst_n = 1'b1;
    run_fixed("post_rst", 7'd4, 15'h4000, 7'd2, 15'h4000, 7'd4, 15'h5000, 1'b0, 6);

    for (int i = 0; i < 60; i++) begin
      e1 = 7'($urandom);
      e2 = 7'(int'(e1) + $urandom_range(0, 38) - 19);
      if ($urandom_range(0, 9) == 0) begin
        e1 = 7'd63;
        e2 = 7'(63 - $urandom_range(0, 2));
      end
      m1 = ($urandom_range(0, 9) == 0) ? 15'd0 : 15'($urandom_range(16384, 32767));
      m2 = ($urandom_range(0, 9) == 0) ? 15'd0 : 15'($urandom_range(16384, 32767));
      ref_add(e1, m1, e2, m2, xe, xm, xovf, xlat);
      run_fixed("rand", e1, m1, e2, m2, xe, xm, xovf, xlat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
